// File: rtl/hazard_pkg.sv
// Shared decode helpers and types for the forwarding / hazard unit.
//   - RV32I opcode constants used by the operand-usage decode
//   - tracker entry type for in-flight destinations behind Execute
//   - uses_rs1 / uses_rs2 / writes_rd / is_load decode functions
package hazard_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } trk_entry_t;

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_RTYPE || op == OP_STORE || op == OP_BRANCH);
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    return !(op == OP_STORE || op == OP_BRANCH);
  endfunction

  function automatic logic is_load(input logic [6:0] op);
    return (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-destination bitmap for long-latency (multi-cycle) operations.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   set_i / set_rd_i      mark a register as pending (wins over a same-cycle clear)
//   clr_i / clr_rd_i      clear a register when its multi-cycle result writes back
//   q_rs1_i/q_rs2_i/q_rd_i  query addresses
//   pend_rs1_o/pend_rs2_o/pend_rd_o  current (registered) pending state of each query
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set_i,
  input  logic [4:0] set_rd_i,
  input  logic       clr_i,
  input  logic [4:0] clr_rd_i,
  input  logic [4:0] q_rs1_i,
  input  logic [4:0] q_rs2_i,
  input  logic [4:0] q_rd_i,
  output logic       pend_rs1_o,
  output logic       pend_rs2_o,
  output logic       pend_rd_o
);

  // Bit 0 is held at zero so x0 never reads as pending.
  logic [31:0] pending_q;
  logic [31:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_i) pending_d[clr_rd_i] = 1'b0;
    if (set_i) pending_d[set_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign pend_rs1_o = pending_q[q_rs1_i];
  assign pend_rs2_o = pending_q[q_rs2_i];
  assign pend_rd_o  = pending_q[q_rd_i];

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding and hazard unit for an N-stage RV32I pipeline.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   issue_valid      instruction_e is a valid instruction in Execute
//   instruction_e    raw instruction in Execute
//   issue_mc         instruction_e goes to the multi-cycle unit
//   flush            instruction_e is squashed this cycle
//   mc_done, mc_rd   multi-cycle unit writes back mc_rd this cycle
//   fwd_a, fwd_b     operand source: 0=RF, k=post-Execute stage k, DEPTH+1=mc result
//   stall            hold Execute and earlier, inject a bubble
//   stall_count      saturating count of stalled cycles
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH      = 1,
  parameter int unsigned LOAD_STAGE = DEPTH,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  input  logic [31:0]                  instruction_e,
  input  logic                         issue_mc,
  input  logic                         flush,
  input  logic                         mc_done,
  input  logic [4:0]                   mc_rd,
  output logic [$clog2(DEPTH+2)-1:0]   fwd_a,
  output logic [$clog2(DEPTH+2)-1:0]   fwd_b,
  output logic                         stall,
  output logic [CNT_W-1:0]             stall_count
);

  localparam int unsigned FW = $clog2(DEPTH + 2);

  typedef struct packed {
    logic [FW-1:0] sel;
    logic          load_use;
    logic          wait_mc;
  } res_t;

  // Decode
  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic       dec_rs1, dec_rs2, dec_wr, dec_load;
  logic       unused_insn_bits;

  assign opcode   = instruction_e[6:0];
  assign rd       = instruction_e[11:7];
  assign rs1      = instruction_e[19:15];
  assign rs2      = instruction_e[24:20];
  assign dec_rs1  = uses_rs1(opcode);
  assign dec_rs2  = uses_rs2(opcode);
  assign dec_wr   = writes_rd(opcode);
  assign dec_load = is_load(opcode);
  assign unused_insn_bits = ^{instruction_e[31:25], instruction_e[14:12]};

  // Tracker: trk_q[1] is the instruction that left Execute last cycle.
  trk_entry_t [DEPTH:1] trk_q;
  trk_entry_t           entry1_d;

  logic pend_rs1, pend_rs2, pend_rd;
  logic sb_set;
  logic waw;
  res_t res_a, res_b;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  // Youngest matching entry decides. A load too young to forward blocks older
  // matches and falls through to the multi-cycle bypass check.
  function automatic res_t resolve(input logic [4:0] s, input logic used,
                                   input logic pend, input logic mc_hit,
                                   input trk_entry_t [DEPTH:1] trk);
    res_t        r;
    logic        hit;
    logic        hit_load;
    int unsigned hit_k;
    r        = '0;
    hit      = 1'b0;
    hit_load = 1'b0;
    hit_k    = 0;
    if (used && s != 5'd0) begin
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        if (!hit && trk[k].valid && trk[k].rd == s) begin
          hit      = 1'b1;
          hit_k    = k;
          hit_load = trk[k].is_load;
        end
      end
      r.load_use = hit && hit_load && (hit_k < LOAD_STAGE);
      if (hit && !r.load_use) r.sel = FW'(hit_k);
      else if (pend && mc_hit) r.sel = FW'(DEPTH + 1);
      r.wait_mc = pend && !mc_hit;
    end
    return r;
  endfunction

  always_comb begin
    res_a = resolve(rs1, dec_rs1, pend_rs1, mc_done && (mc_rd == rs1), trk_q);
    res_b = resolve(rs2, dec_rs2, pend_rs2, mc_done && (mc_rd == rs2), trk_q);
  end

  assign waw   = dec_wr && (rd != 5'd0) && pend_rd && !(mc_done && (mc_rd == rd));
  assign stall = issue_valid && !flush &&
                 (res_a.load_use || res_a.wait_mc || res_b.load_use || res_b.wait_mc || waw);
  assign fwd_a = res_a.sel;
  assign fwd_b = res_b.sel;

  assign sb_set = issue_valid && issue_mc && dec_wr && !flush && !stall && (rd != 5'd0);

  hazard_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_i      (sb_set),
    .set_rd_i   (rd),
    .clr_i      (mc_done),
    .clr_rd_i   (mc_rd),
    .q_rs1_i    (rs1),
    .q_rs2_i    (rs2),
    .q_rd_i     (rd),
    .pend_rs1_o (pend_rs1),
    .pend_rs2_o (pend_rs2),
    .pend_rd_o  (pend_rd)
  );

  always_comb begin
    entry1_d.valid   = issue_valid && !flush && !stall && dec_wr && !issue_mc && (rd != 5'd0);
    entry1_d.rd      = rd;
    entry1_d.is_load = dec_load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_q <= '0;
    end else begin
      trk_q[1] <= entry1_d;
      for (int unsigned k = 1; k < DEPTH; k++) trk_q[k+1] <= trk_q[k];
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && stall_count_q != '1) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_count_q <= '0;
    else     stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  localparam int unsigned D1 = 1, L1 = 1, C1 = 4;
  localparam int unsigned D2 = 2, L2 = 2, C2 = 32;

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, LOAD = 7'b0000011, STORE = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011, RTYPE = 7'b0110011, ITYPE = 7'b0010011;

  logic        clk, rst;
  logic        issue_valid, issue_mc, flush, mc_done;
  logic [31:0] instruction_e;
  logic [4:0]  mc_rd;
  logic [1:0]  fa1, fb1, fa2, fb2;
  logic        st1, st2;
  logic [3:0]  sc1;
  logic [31:0] sc2;

  int tests_run = 0;
  int failed    = 0;

  hazard_forward_unit #(.DEPTH(D1), .LOAD_STAGE(L1), .CNT_W(C1)) u_d1 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .instruction_e(instruction_e),
    .issue_mc(issue_mc), .flush(flush), .mc_done(mc_done), .mc_rd(mc_rd),
    .fwd_a(fa1), .fwd_b(fb1), .stall(st1), .stall_count(sc1));

  hazard_forward_unit #(.DEPTH(D2), .LOAD_STAGE(L2), .CNT_W(C2)) u_d2 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .instruction_e(instruction_e),
    .issue_mc(issue_mc), .flush(flush), .mc_done(mc_done), .mc_rd(mc_rd),
    .fwd_a(fa2), .fwd_b(fb2), .stall(st2), .stall_count(sc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(input logic [4:0] rd, rs1, rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, RTYPE};
  endfunction
  function automatic logic [31:0] enc_mul(input logic [4:0] rd, rs1, rs2);
    return {7'd1, rs2, rs1, 3'd0, rd, RTYPE};
  endfunction
  function automatic logic [31:0] enc_addi(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'd0, rd, ITYPE};
  endfunction
  function automatic logic [31:0] enc_lw(input logic [4:0] rd, rs1);
    return {12'd0, rs1, 3'b010, rd, LOAD};
  endfunction

  task automatic drive(input logic v, input logic [31:0] insn, input logic mc,
                       input logic fl, input logic done, input logic [4:0] mrd);
    issue_valid = v; instruction_e = insn; issue_mc = mc;
    flush = fl; mc_done = done; mc_rd = mrd;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 5'd0);
    repeat (n) step();
  endtask

  // ---------------- reference model (issue history by age + pending set) ----------------
  bit         hv [2][1:2];
  logic [4:0] hrd[2][1:2];
  bit         hld[2][1:2];
  bit         pend[2][32];
  longint     cnt[2];

  function automatic int depth_of(input int id);
    return (id == 0) ? int'(D1) : int'(D2);
  endfunction
  function automatic int lstage_of(input int id);
    return (id == 0) ? int'(L1) : int'(L2);
  endfunction
  function automatic longint cmax_of(input int id);
    return (id == 0) ? 64'd15 : 64'hFFFF_FFFF;
  endfunction

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      for (int a = 1; a <= 2; a++) begin hv[id][a] = 0; hrd[id][a] = '0; hld[id][a] = 0; end
      for (int r = 0; r < 32; r++) pend[id][r] = 0;
      cnt[id] = 0;
    end
  endtask

  task automatic src_eval(input int id, input logic [4:0] s, input bit used,
                          output int sel, output bit haz);
    int age_hit;
    bit done_now, early_load;
    sel = 0; haz = 0; age_hit = 0;
    if (used && s != 5'd0) begin
      for (int a = depth_of(id); a >= 1; a--)
        if (hv[id][a] && hrd[id][a] == s) age_hit = a;
      done_now   = pend[id][s] && mc_done && (mc_rd == s);
      early_load = (age_hit != 0) && hld[id][age_hit] && (age_hit < lstage_of(id));
      if (age_hit != 0 && !early_load) sel = age_hit;
      else if (done_now)               sel = depth_of(id) + 1;
      haz = early_load || (pend[id][s] && !done_now);
    end
  endtask

  task automatic model_eval(input int id, output int ea, output int eb, output bit est);
    logic [6:0] op;
    logic [4:0] rd, rs1, rs2;
    bit u1, u2, w, h1, h2, waw;
    op = instruction_e[6:0]; rd = instruction_e[11:7];
    rs1 = instruction_e[19:15]; rs2 = instruction_e[24:20];
    u1 = !(op == LUI || op == AUIPC || op == JAL);
    u2 = (op == RTYPE || op == STORE || op == BRANCH);
    w  = !(op == STORE || op == BRANCH);
    src_eval(id, rs1, u1, ea, h1);
    src_eval(id, rs2, u2, eb, h2);
    waw = w && rd != 5'd0 && pend[id][rd] && !(mc_done && mc_rd == rd);
    est = issue_valid && !flush && (h1 || h2 || waw);
  endtask

  task automatic model_step(input int id, input bit est);
    logic [6:0] op;
    logic [4:0] rd;
    bit w, accepted;
    op = instruction_e[6:0]; rd = instruction_e[11:7];
    w = !(op == STORE || op == BRANCH);
    accepted = issue_valid && !flush && !est && w && rd != 5'd0;
    for (int a = depth_of(id); a >= 2; a--) begin
      hv[id][a] = hv[id][a-1]; hrd[id][a] = hrd[id][a-1]; hld[id][a] = hld[id][a-1];
    end
    hv[id][1] = accepted && !issue_mc; hrd[id][1] = rd; hld[id][1] = (op == LOAD);
    if (mc_done) pend[id][mc_rd] = 0;
    if (accepted && issue_mc) pend[id][rd] = 1;
    if (est && cnt[id] < cmax_of(id)) cnt[id]++;
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset();
    drive(1'b1, enc_r(5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, 5'd0);
    rst = 1'b0; #1 rst = 1'b1; #1;
    tests_run++; if (st1 !== 1'b0 || st2 !== 1'b0) begin failed++; $display("FAIL reset_stall got %b/%b want 0/0", st1, st2); end
    tests_run++; if (fa1 !== 2'd0 || fb1 !== 2'd0 || fa2 !== 2'd0 || fb2 !== 2'd0) begin failed++; $display("FAIL reset_fwd got %0d %0d %0d %0d want 0", fa1, fb1, fa2, fb2); end
    tests_run++; if (sc1 !== 4'd0 || sc2 !== 32'd0) begin failed++; $display("FAIL reset_count got %0d/%0d want 0/0", sc1, sc2); end
    step(); step();
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_load_use();
    drive(1'b1, enc_lw(5'd7, 5'd1), 1'b0, 1'b0, 1'b0, 5'd0);
    step();
    drive(1'b1, enc_r(5'd8, 5'd7, 5'd0), 1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    tests_run++; if (st2 !== 1'b1) begin failed++; $display("FAIL load_use_stall got %b want 1", st2); end
    tests_run++; if (st1 !== 1'b0 || fa1 !== 2'd1) begin failed++; $display("FAIL load_d1_fwd got st=%b fa=%0d want st=0 fa=1", st1, fa1); end
    step();
    tests_run++; if (st2 !== 1'b0 || fa2 !== 2'd2) begin failed++; $display("FAIL load_use_after got st=%b fa=%0d want st=0 fa=2", st2, fa2); end
    tests_run++; if (sc2 !== 32'd1) begin failed++; $display("FAIL load_use_count got %0d want 1", sc2); end
    idle(3);
  endtask

  task automatic test_fwd_d1();
    drive(1'b1, enc_r(5'd5, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, 5'd0);
    step();
    drive(1'b1, enc_r(5'd6, 5'd5, 5'd5), 1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    tests_run++; if (fa1 !== 2'd1 || fb1 !== 2'd1 || st1 !== 1'b0) begin failed++; $display("FAIL d1_fwd got fa=%0d fb=%0d st=%b want 1 1 0", fa1, fb1, st1); end
    step();
    drive(1'b1, enc_r(5'd11, 5'd5, 5'd6), 1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    tests_run++; if (fa2 !== 2'd2 || fb2 !== 2'd1) begin failed++; $display("FAIL d2_age_fwd got fa=%0d fb=%0d want 2 1", fa2, fb2); end
    tests_run++; if (fa1 !== 2'd0 || fb1 !== 2'd1) begin failed++; $display("FAIL d1_retire got fa=%0d fb=%0d want 0 1", fa1, fb1); end
    idle(3);
  endtask

  task automatic test_youngest();
    drive(1'b1, enc_addi(5'd3, 5'd0, 12'd1), 1'b0, 1'b0, 1'b0, 5'd0); step();
    drive(1'b1, enc_addi(5'd3, 5'd0, 12'd2), 1'b0, 1'b0, 1'b0, 5'd0); step();
    drive(1'b1, enc_r(5'd4, 5'd3, 5'd3), 1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    tests_run++; if (fa2 !== 2'd1 || fb2 !== 2'd1 || st2 !== 1'b0) begin failed++; $display("FAIL youngest got fa=%0d fb=%0d st=%b want 1 1 0", fa2, fb2, st2); end
    idle(3);
  endtask

  task automatic test_scoreboard();
    drive(1'b1, enc_mul(5'd9, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 5'd0);
    #1;
    tests_run++; if (st1 !== 1'b0 || st2 !== 1'b0) begin failed++; $display("FAIL mul_issue_stall got %b/%b want 0/0", st1, st2); end
    step();
    drive(1'b1, enc_r(5'd10, 5'd9, 5'd0), 1'b0, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++; if (st1 !== 1'b1 || st2 !== 1'b1) begin failed++; $display("FAIL sb_wait%0d got %b/%b want 1/1", i, st1, st2); end
      step();
    end
    drive(1'b1, enc_r(5'd10, 5'd9, 5'd0), 1'b0, 1'b0, 1'b1, 5'd9);
    #1;
    tests_run++; if (fa1 !== 2'd2 || fa2 !== 2'd3 || st1 !== 1'b0 || st2 !== 1'b0) begin failed++; $display("FAIL sb_bypass got fa=%0d/%0d st=%b/%b want 2/3 0/0", fa1, fa2, st1, st2); end
    tests_run++; if (sc1 !== 4'd3 || sc2 !== 32'd4) begin failed++; $display("FAIL sb_count got %0d/%0d want 3/4", sc1, sc2); end
    step();
    drive(1'b1, enc_r(5'd12, 5'd9, 5'd0), 1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    tests_run++; if (st1 !== 1'b0 || st2 !== 1'b0 || fa2 !== 2'd0) begin failed++; $display("FAIL sb_cleared got st=%b/%b fa=%0d want 0/0 0", st1, st2, fa2); end
    idle(3);
  endtask

  task automatic test_x0_flush();
    drive(1'b1, enc_r(5'd0, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, 5'd0); step();
    drive(1'b1, enc_r(5'd1, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    tests_run++; if (fa1 !== 2'd0 || fb1 !== 2'd0 || fa2 !== 2'd0 || fb2 !== 2'd0) begin failed++; $display("FAIL x0_fwd got %0d %0d %0d %0d want 0", fa1, fb1, fa2, fb2); end
    step();
    drive(1'b1, enc_lw(5'd7, 5'd1), 1'b0, 1'b0, 1'b0, 5'd0); step();
    drive(1'b1, enc_r(5'd8, 5'd7, 5'd0), 1'b0, 1'b1, 1'b0, 5'd0);
    #1;
    tests_run++; if (st2 !== 1'b0) begin failed++; $display("FAIL flush_stall got %b want 0", st2); end
    step();
    drive(1'b1, enc_r(5'd12, 5'd8, 5'd0), 1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    tests_run++; if (fa2 !== 2'd0 || fa1 !== 2'd0) begin failed++; $display("FAIL flush_no_entry got fa=%0d/%0d want 0/0", fa1, fa2); end
    idle(3);
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, enc_mul(5'd9, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 5'd0); step();
    drive(1'b1, enc_r(5'd10, 5'd9, 5'd0), 1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    tests_run++; if (st1 !== 1'b1 || st2 !== 1'b1) begin failed++; $display("FAIL pre_reset_stall got %b/%b want 1/1", st1, st2); end
    step();
    rst = 1'b1; #1;
    tests_run++; if (st1 !== 1'b0 || st2 !== 1'b0) begin failed++; $display("FAIL async_reset_stall got %b/%b want 0/0", st1, st2); end
    tests_run++; if (sc1 !== 4'd0 || sc2 !== 32'd0) begin failed++; $display("FAIL async_reset_count got %0d/%0d want 0/0", sc1, sc2); end
    step();
    rst = 1'b0; #1;
    tests_run++; if (st1 !== 1'b0 || st2 !== 1'b0) begin failed++; $display("FAIL post_reset_pending got %b/%b want 0/0", st1, st2); end
    idle(2);
  endtask

  task automatic test_saturation();
    drive(1'b1, enc_mul(5'd9, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0, 5'd0); step();
    drive(1'b1, enc_r(5'd10, 5'd9, 5'd0), 1'b0, 1'b0, 1'b0, 5'd0);
    repeat (14) step();
    tests_run++; if (sc1 !== 4'd14 || st1 !== 1'b1) begin failed++; $display("FAIL sat_pre got cnt=%0d st=%b want 14 1", sc1, st1); end
    repeat (6) step();
    tests_run++; if (sc1 !== 4'd15) begin failed++; $display("FAIL sat_hold got %0d want 15", sc1); end
    tests_run++; if (sc2 !== 32'd20) begin failed++; $display("FAIL sat_wide got %0d want 20", sc2); end
    drive(1'b1, enc_r(5'd10, 5'd9, 5'd0), 1'b0, 1'b0, 1'b1, 5'd9); step();
    idle(3);
  endtask

  // ---------------- randomized run against the model ----------------
  task automatic test_random();
    logic [6:0] ops[9];
    logic [6:0] op;
    int ea[2], eb[2];
    bit est[2];
    ops = '{LUI, AUIPC, JAL, JALR, LOAD, STORE, BRANCH, RTYPE, ITYPE};
    rst = 1'b1; #1 rst = 1'b0;
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      op = ops[$urandom_range(0, 8)];
      drive($urandom_range(0, 4) != 0,
            {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
             5'($urandom_range(0, 7)), op},
            (op == RTYPE) && ($urandom_range(0, 3) == 0),
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) == 0,
            5'($urandom_range(0, 7)));
      #1;
      model_eval(0, ea[0], eb[0], est[0]);
      model_eval(1, ea[1], eb[1], est[1]);
      tests_run++; if (fa1 !== 2'(ea[0]) || fb1 !== 2'(eb[0])) begin failed++; $display("FAIL rnd_d1_fwd cyc %0d got %0d %0d want %0d %0d", n, fa1, fb1, ea[0], eb[0]); end
      tests_run++; if (fa2 !== 2'(ea[1]) || fb2 !== 2'(eb[1])) begin failed++; $display("FAIL rnd_d2_fwd cyc %0d got %0d %0d want %0d %0d", n, fa2, fb2, ea[1], eb[1]); end
      tests_run++; if (st1 !== est[0] || st2 !== est[1]) begin failed++; $display("FAIL rnd_stall cyc %0d got %b/%b want %b/%b", n, st1, st2, est[0], est[1]); end
      tests_run++; if (sc1 !== 4'(cnt[0]) || sc2 !== 32'(cnt[1])) begin failed++; $display("FAIL rnd_count cyc %0d got %0d/%0d want %0d/%0d", n, sc1, sc2, cnt[0], cnt[1]); end
      @(posedge clk);
      model_step(0, est[0]);
      model_step(1, est[1]);
      #1;
    end
    idle(2);
  endtask

  initial begin
    drive(1'b0, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 5'd0);
    test_reset();
    test_load_use();
    test_fwd_d1();
    test_youngest();
    test_scoreboard();
    test_x0_flush();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised forwarding and hazard unit for the generalised N-stage RV32I pipeline; successor to the single-stage, combinational W→E forwarding logic.
- Tracks destination registers of in-flight instructions behind Execute in an internal shift pipeline, and tracks long-latency (mul/div) destinations in a scoreboard.
- Outputs per-operand forward selects for Execute, a load-use/scoreboard stall, and a saturating stall-cycle counter.

Parameters:
- DEPTH, 1, stages after Execute whose results are forwardable (1 = 3-stage pipeline, W only).
- LOAD_STAGE, DEPTH, first post-Execute stage (1..DEPTH) where load data is available.
- CNT_W, 32, width of stall_count.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- issue_valid  in  1  instruction_e holds a valid instruction in Execute
- instruction_e  in  32  raw instruction in Execute
- issue_mc  in  1  instruction_e dispatches to the multi-cycle unit
- flush  in  1  instruction_e squashed this cycle
- mc_done  in  1  multi-cycle unit writes back this cycle
- mc_rd  in  5  destination of the completing multi-cycle op
- fwd_a  out  $clog2(DEPTH+2)  rs1 source: 0=RF, k=stage k, DEPTH+1=mc result
- fwd_b  out  $clog2(DEPTH+2)  rs2 source, same encoding
- stall  out  1  hold Execute and earlier; inject bubble
- stall_count  out  CNT_W  cycles with stall=1, saturating

Behaviour:
- Decode (combinational, from instruction_e):
  - uses_rs1 = 0 for LUI, AUIPC, JAL.
  - uses_rs2 = 1 only for R, S, B types.
  - writes_rd = 0 for S, B.
  - is_load = opcode 0000011.
  - Register x0 is never a hazard or forward target.
- Tracker: entries 1..DEPTH, each {valid, rd, is_load}, updated every posedge.
  - Entry1 <= {issue_valid & ~flush & ~stall & writes_rd & ~issue_mc & rd!=0, rd, is_load}; a stall loads a bubble into entry1.
  - Entry k+1 <= entry k unconditionally. Entry DEPTH retires.
- Scoreboard: pending[31:1].
  - Set rd when issue_valid & issue_mc & writes_rd & ~flush & ~stall & rd!=0.
  - Clear mc_rd when mc_done.
  - Same-cycle set and clear of the same rd: set wins.
- Forward select per used source s (combinational):
  - Youngest valid entry k with rd==s gives fwd=k, provided entry k is not a load or k>=LOAD_STAGE.
  - Otherwise, if pending[s] & mc_done & mc_rd==s: fwd=DEPTH+1.
  - Otherwise fwd=0. Unused sources give fwd=0.
- Stall (combinational) is asserted when issue_valid & ~flush and any of:
  - (a) Load-use: a used source's youngest match is a load with k<LOAD_STAGE.
  - (b) A used source is pending and not completing this cycle.
  - (c) WAW: writes_rd & rd!=0 & pending[rd] & ~(mc_done & mc_rd==rd).
- flush forces stall=0 and suppresses all state updates from instruction_e.
- stall_count: +1 each cycle stall=1; holds at all-ones.
- Reset (async, any time including mid-stall):
  - All entries invalid, pending=0, stall_count=0.
  - fwd_a, fwd_b, stall are then 0 for any input lacking a hazard.
- Latency: forward/stall decisions are same-cycle combinational. A producer is visible to the next instruction one cycle after issue.

Decomposition:
- Shared package hazard_pkg holds:
  - Opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_LOAD, OP_STORE, OP_BRANCH, OP_RTYPE, OP_ITYPE).
  - The tracker entry struct typedef.
  - Functions uses_rs1/uses_rs2/writes_rd.
- One sub-module: hazard_scoreboard (pending bitmap with set/clear/query ports). Tracker and forward-priority logic stay in the top module.

Test Plan:
- DEPTH=1: issue add x5,x1,x2, then add x6,x5,x5 -> second cycle fwd_a=1, fwd_b=1, stall=0.
- DEPTH=2, LOAD_STAGE=2: lw x7,0(x1) then add x8,x7,x0 -> stall=1 for exactly 1 cycle, stall_count=1; next cycle fwd_a=2, stall=0.
- Youngest wins, DEPTH=2: addi x3,x0,1; addi x3,x0,2; add x4,x3,x3 -> fwd_a=fwd_b=1, not 2.
- Scoreboard: issue_mc mul x9 (accepted), then add x10,x9,x0 -> stall held until mc_done&mc_rd=9; in that cycle fwd_a=DEPTH+1, stall=0; pending[9]=0 afterwards.
- x0/flush: add x0,… then add x1,x0,x0 -> fwd 0/0; flush with a load-use hazard -> stall=0 and no tracker entry written.
- Reset mid-stall: assert rst while stall=1 from a pending x9 -> pending cleared, stall_count=0, stall=0 immediately, without waiting for a clock edge.
